// File: rtl/multi_digit_display_if.sv
// ---------------------------------------------------------------------------
// multi_digit_display_if
//   Bundle between display-value logic and the multiplexed seven-segment
//   driver.
//
//   Data towards the driver (master drives, slave samples):
//     value       4*NUM_DIGITS  hex nibbles. Digit i is value[4i+3:4i].
//                               Digit 0 is the rightmost digit.
//     dp          NUM_DIGITS    decimal point per digit
//     blank       NUM_DIGITS    force digit dark
//     blink       NUM_DIGITS    digit dark during the blink-off phase
//     lz_suppress 1             enable leading-zero suppression
//     brightness  BRIGHT_W      duty level. All-ones means full brightness.
//
//   Pin-level outputs of the driver (slave drives, master observes):
//     seg         7             {a,b,c,d,e,f,g}
//     seg_dp      1             decimal-point segment
//     digit_en    NUM_DIGITS    digit enables
//     frame_tick  1             one-cycle pulse at frame start
// ---------------------------------------------------------------------------
interface multi_digit_display_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 3
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lz_suppress;
    logic [BRIGHT_W-1:0]     brightness;

    logic [6:0]              seg;
    logic                    seg_dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_tick;

    modport master (
        output value, dp, blank, blink, lz_suppress, brightness,
        input  seg, seg_dp, digit_en, frame_tick
    );

    modport slave (
        input  value, dp, blank, blink, lz_suppress, brightness,
        output seg, seg_dp, digit_en, frame_tick
    );
endinterface

// File: rtl/multi_digit_display.sv
// ---------------------------------------------------------------------------
// multi_digit_display
//   Parametrised N-digit multiplexed seven-segment driver. It provides:
//     - hex decode
//     - per-digit decimal point, blank and blink
//     - leading-zero suppression
//     - PWM brightness
//   Display inputs are captured into shadow registers once per frame. A value
//   that changes mid-frame therefore never shows partly old and partly new.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset. Outputs go inactive at once.
//     disp   slave side of multi_digit_display_if (data in, pins out)
// ---------------------------------------------------------------------------
module multi_digit_display #(
    parameter int NUM_DIGITS      = 8,
    parameter int CLK_FREQ        = 50_000_000,
    parameter int REFRESH_HZ      = 100,
    parameter int BRIGHT_W        = 3,
    parameter int BLINK_HZ        = 2,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int EN_ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_digit_display_if.slave disp
);
    localparam int SCAN_CNT_MAX  = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CNT_W         = (SCAN_CNT_MAX > 2) ? $clog2(SCAN_CNT_MAX) : 1;
    localparam int IDX_W         = $clog2(NUM_DIGITS);
    localparam int BLINK_DIV_RAW = REFRESH_HZ / (2 * BLINK_HZ);
    localparam int BLINK_DIV     = (BLINK_DIV_RAW < 1) ? 1 : BLINK_DIV_RAW;
    localparam int BLINK_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    // Holds (bright+1)*SCAN_CNT_MAX without overflow.
    localparam int PROD_W        = BRIGHT_W + CNT_W + 2;

    if (SCAN_CNT_MAX < (1 << BRIGHT_W)) begin : g_bad_scan_cfg
        $error("multi_digit_display: SCAN_CNT_MAX below 2**BRIGHT_W");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digit_cfg
        $error("multi_digit_display: NUM_DIGITS must be 2..16");
    end

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]                scan_cnt_q,  scan_cnt_d;
    logic [IDX_W-1:0]                digit_idx_q, digit_idx_d;
    logic [BRIGHT_W-1:0]             bright_q,    bright_d;
    logic [BLINK_W-1:0]              blink_cnt_q, blink_cnt_d;
    logic                            blink_on_q,  blink_on_d;
    logic [NUM_DIGITS-1:0][3:0]      nib_sh_q,    nib_sh_d;
    logic [NUM_DIGITS-1:0]           dp_sh_q,     dp_sh_d;
    logic [NUM_DIGITS-1:0]           blank_sh_q,  blank_sh_d;
    logic [NUM_DIGITS-1:0]           blink_sh_q,  blink_sh_d;
    // Output registers hold the logical (active-high) form of the outputs.
    logic [6:0]                      seg_q,       seg_d;
    logic                            seg_dp_q,    seg_dp_d;
    logic [NUM_DIGITS-1:0]           en_q,        en_d;
    logic                            frame_tick_q, frame_tick_d;

    logic                  scan_wrap;
    logic                  frame_wrap;
    logic [PROD_W-1:0]     on_cycles;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_run;
    logic                  dark;

    assign scan_wrap  = (scan_cnt_q == CNT_W'(SCAN_CNT_MAX - 1));
    assign frame_wrap = scan_wrap && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
    assign on_cycles  = (PROD_W'({1'b0, bright_q} + 1'b1) * PROD_W'(SCAN_CNT_MAX)) >> BRIGHT_W;

    // Leading-zero suppression. Walk from the most significant digit down.
    // The run of suppressible digits ends at the first non-zero nibble or
    // set decimal point. Digit 0 always stays visible.
    always_comb begin
        // NOTE: zero_run is a loop-carried temporary, so it is assigned with
        // blocking '=' here. State registers use '<=' only, in always_ff.
        zero_run = disp.lz_suppress;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (nib_sh_q[i] == 4'h0) && !dp_sh_q[i];
            suppress[i] = (i != 0) && zero_run;
        end
    end

    // Next-state and output decisions.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d  = digit_idx_q;
        bright_d     = bright_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        nib_sh_d     = nib_sh_q;
        dp_sh_d      = dp_sh_q;
        blank_sh_d   = blank_sh_q;
        blink_sh_d   = blink_sh_q;
        frame_tick_d = frame_wrap;

        if (scan_wrap) begin
            digit_idx_d = frame_wrap ? '0 : digit_idx_q + 1'b1;
            bright_d    = disp.brightness;
        end

        if (frame_wrap) begin
            nib_sh_d   = disp.value;
            dp_sh_d    = disp.dp;
            blank_sh_d = disp.blank;
            blink_sh_d = disp.blink;
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        dark = blank_sh_q[digit_idx_q]
            || (blink_sh_q[digit_idx_q] && !blink_on_q)
            || suppress[digit_idx_q]
            || (PROD_W'(scan_cnt_q) >= on_cycles);

        seg_d    = '0;
        seg_dp_d = 1'b0;
        en_d     = '0;
        if (!dark) begin
            seg_d    = decode(nib_sh_q[digit_idx_q]);
            seg_dp_d = dp_sh_q[digit_idx_q];
            en_d     = NUM_DIGITS'(1) << digit_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q   <= '0;
            digit_idx_q  <= '0;
            bright_q     <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            // NOTE: the shadow registers are reset as well. The first frame
            // then shows defined zeros instead of power-up garbage.
            nib_sh_q     <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '0;
            blink_sh_q   <= '0;
            seg_q        <= '0;
            seg_dp_q     <= 1'b0;
            en_q         <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            bright_q     <= bright_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            nib_sh_q     <= nib_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            blink_sh_q   <= blink_sh_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            en_q         <= en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Board polarity is a pure inversion after the flops. The reset value of
    // each flop therefore reaches the pins as the inactive level.
    assign disp.seg        = seg_q ^ {7{SEG_ACTIVE_HIGH == 0}};
    assign disp.seg_dp     = seg_dp_q ^ (SEG_ACTIVE_HIGH == 0);
    assign disp.digit_en   = en_q ^ {NUM_DIGITS{EN_ACTIVE_LOW != 0}};
    assign disp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// ---------------------------------------------------------------------------
// tb_multi_digit_display
//   Bench configuration:
//     5 digits, 8 kHz clk, 100 Hz refresh, 25 Hz blink, BRIGHT_W = 2
//     This gives 16 clocks per digit slot and 80 clocks per frame.
//
//   The expected pin state after every clock edge is derived from the edge
//   number k counted since reset release:
//     - slot position, digit index and frame number come from k;
//     - shadow and brightness values are looked up in a per-edge history of
//       the driven inputs.
// ---------------------------------------------------------------------------
module tb_multi_digit_display;
    localparam int N    = 5;
    localparam int SLOT = 16;
    localparam int FRM  = SLOT * N;
    localparam int HIST = 8192;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic clk = 1'b0;
    logic rst_n;

    multi_digit_display_if #(.NUM_DIGITS(N), .BRIGHT_W(2)) disp ();

    multi_digit_display #(
        .NUM_DIGITS(N), .CLK_FREQ(8000), .REFRESH_HZ(100), .BRIGHT_W(2),
        .BLINK_HZ(25), .SEG_ACTIVE_HIGH(1), .EN_ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (disp)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int k      = 0;

    logic [19:0] h_value [HIST];
    logic [4:0]  h_dp    [HIST];
    logic [4:0]  h_blank [HIST];
    logic [4:0]  h_blink [HIST];
    logic        h_lz    [HIST];
    logic [1:0]  h_br    [HIST];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    task automatic check_inactive(input string tag);
        check({tag, "_en"},  32'(disp.digit_en), 32'h1f);
        check({tag, "_seg"}, 32'(disp.seg), 32'h0);
        check({tag, "_dp"},  32'(disp.seg_dp), 32'h0);
        check({tag, "_ft"},  32'(disp.frame_tick), 32'h0);
    endtask

    // Expected pins after edge k. They reflect the state that held before
    // that edge (edge index s = k-1) and the lz_suppress level at edge k.
    task automatic check_model();
        int s, m, pos, idx, f, br, on;
        logic [19:0] val;
        logic [4:0]  dpv, blk, bli;
        logic        phase_on, supp, drk;
        logic [4:0]  exp_en;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        s   = k - 1;
        m   = s / SLOT;
        pos = s % SLOT;
        idx = m % N;
        f   = s / FRM;
        br  = (m == 0) ? 0 : int'(h_br[SLOT * m]);
        val = (f == 0) ? '0 : h_value[FRM * f];
        dpv = (f == 0) ? '0 : h_dp[FRM * f];
        blk = (f == 0) ? '0 : h_blank[FRM * f];
        bli = (f == 0) ? '0 : h_blink[FRM * f];
        // The blink phase toggles every 2 frames and starts "on".
        phase_on = ((f / 2) % 2) == 0;
        on  = ((br + 1) * SLOT) / 4;
        supp = 1'b0;
        if (idx > 0 && h_lz[k]) begin
            supp = 1'b1;
            for (int j = idx; j < N; j++)
                if (val[4*j +: 4] != 4'h0 || dpv[j]) supp = 1'b0;
        end
        drk = blk[idx] || (bli[idx] && !phase_on) || supp || (pos >= on);
        exp_en  = drk ? 5'b11111 : ~(5'b00001 << idx);
        exp_seg = drk ? 7'b0 : SEG_TAB[val[4*idx +: 4]];
        exp_dp  = !drk && dpv[idx];
        check("digit_en",   32'(disp.digit_en), 32'(exp_en));
        check("seg",        32'(disp.seg), 32'(exp_seg));
        check("seg_dp",     32'(disp.seg_dp), 32'(exp_dp));
        check("frame_tick", 32'(disp.frame_tick), 32'((k % FRM) == 0));
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        if (k >= HIST) begin
            $error("FAIL history_budget k=%0d observed=overflow expected=<%0d", k, HIST);
            $fatal(1, "history budget exceeded");
        end
        h_value[k] = disp.value;
        h_dp[k]    = disp.dp;
        h_blank[k] = disp.blank;
        h_blink[k] = disp.blink;
        h_lz[k]    = disp.lz_suppress;
        h_br[k]    = disp.brightness;
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
    endtask

    initial begin
        rst_n            = 1'b0;
        disp.value       = '0;
        disp.dp          = '0;
        disp.blank       = '0;
        disp.blink       = '0;
        disp.lz_suppress = 1'b0;
        disp.brightness  = '0;
        #23;
        check_inactive("reset");

        // Basic scan at full brightness.
        disp.value      = 20'h12345;
        disp.brightness = 2'd3;
        release_reset();
        run(3 * FRM);

        // Leading-zero suppression.
        disp.value       = 20'h00030;
        disp.lz_suppress = 1'b1;
        run(2 * FRM);
        disp.dp = 5'b01000;
        run(2 * FRM);
        disp.value = '0;
        disp.dp    = '0;
        run(2 * FRM);

        // Brightness levels, including a change in the middle of a slot.
        disp.lz_suppress = 1'b0;
        disp.value       = 20'h9ABCD;
        disp.brightness  = 2'd1;
        run(2 * FRM);
        disp.brightness = 2'd0;
        run(2 * FRM);
        run(7);
        disp.brightness = 2'd2;
        run(SLOT + 9);
        disp.brightness = 2'd3;
        run(SLOT);

        // Value changing in the middle of a frame.
        disp.value = 20'h11111;
        run(FRM + 40);
        disp.value = 20'h22222;
        run(2 * FRM);

        // Blink and blank.
        disp.blink = 5'b00001;
        run(8 * FRM);
        disp.blink = '0;
        disp.blank = 5'b00010;
        run(2 * FRM);

        // Randomised inputs.
        repeat (30 * FRM) begin
            if ($urandom_range(0, 15) == 0) begin
                disp.value       = 20'($urandom) >> (4 * $urandom_range(0, 5));
                disp.dp          = 5'($urandom & $urandom);
                disp.blank       = 5'($urandom & $urandom & $urandom);
                disp.blink       = 5'($urandom & $urandom);
                disp.lz_suppress = 1'($urandom);
                disp.brightness  = 2'($urandom);
            end
            step();
        end

        // Reset asserted in the middle of a lit slot.
        disp.value       = 20'hABCDE;
        disp.dp          = 5'b10101;
        disp.blank       = '0;
        disp.blink       = '0;
        disp.lz_suppress = 1'b0;
        disp.brightness  = 2'd3;
        run(2 * FRM + 5);
        #3;
        rst_n = 1'b0;
        #1;
        check_inactive("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_inactive("held_reset");
        release_reset();
        run(3 * FRM);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
